act_pwl: RTL
============

ACT_PWL -- requirements
Module: act_pwl

Interface
REQ-001 Parameter WIDTH, default 24: two's-complement data width; legal when WIDTH >= FRAC+3.
REQ-002 Parameter FRAC, default 20: fractional bits; ONE = 2^FRAC (0x100000 at defaults).
REQ-003 Port clk, input, 1: the only clock; every register updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port i_valid, input, 1: i_data and i_mode are valid this cycle.
REQ-006 Port i_ready, output, 1: block accepts i_data this cycle.
REQ-007 Port i_data, input, WIDTH: operand x, signed fixed point.
REQ-008 Port i_mode, input, 1: 0 = tanh, 1 = sigmoid; captured with i_data.
REQ-009 Port o_valid, output, 1: o_data is valid.
REQ-010 Port o_ready, input, 1: downstream accepts o_data.
REQ-011 Port o_data, output, WIDTH: activation result, same format as i_data.
REQ-012 Port o_sat, output, 1: o_data came from the saturated region.

Function
REQ-013 Tanh core T(v), with a = |v| computed in WIDTH+1 bits (the most negative input does not overflow) and all shifts arithmetic:
- a < ONE/2: v
- ONE/2 <= a < ONE: v/2 + ONE/4 if v >= 0; v/2 - ONE/4 otherwise
- ONE <= a < 2*ONE: v/4 + ONE/2 if v >= 0; v/4 - ONE/2 otherwise
- a >= 2*ONE: +ONE if v >= 0; -ONE otherwise (the saturated region)
REQ-014 Tanh mode: o_data = T(x); o_sat is set when T(x) is in the saturated region.
REQ-015 Sigmoid mode: o_data = ONE/2 + T(x>>>1)>>>1; o_sat is set when T(x>>>1) is in the saturated region.
REQ-016 Two-stage pipeline:
- Stage 1 registers the operand, mode, sign and the 2-bit region code.
- Stage 2 registers o_data, o_sat and o_valid.
- Latency is 2 cycles from input handshake to o_valid.
REQ-017 Global stall: enable = ~o_valid | o_ready; i_ready = enable; both stages advance only when enable is 1.
REQ-018 Input transfer occurs on i_valid & i_ready; output transfer occurs on o_valid & o_ready.
REQ-019 Throughput is one result per cycle while o_ready stays 1.
REQ-020 Results leave in acceptance order; no data is lost or duplicated under backpressure.
REQ-021 While stalled, o_data and o_sat hold stable.
REQ-022 An empty slot (no input transfer) propagates as a bubble; o_valid stays 0 for that slot.

Reset
REQ-023 While rst_n is 0, stage valids, o_valid, o_data and o_sat are 0, and the counter of REQ-027 is 0.
REQ-024 Reset asserted mid-operation discards all in-flight operands; no result is produced for them.
REQ-025 i_ready is 1 from the first cycle after rst_n deasserts.

Configuration
REQ-026 Macro ACT_PWL_SATCNT_EN controls the saturation counter; when it is undefined, the ports sat_clr and sat_cnt do not exist and no counter logic is built.
REQ-027 With ACT_PWL_SATCNT_EN defined:
- Port sat_clr, input, 1: synchronous clear.
- Port sat_cnt, output, 16: number of output transfers with o_sat = 1.
- The counter saturates at 0xFFFF and does not wrap.
- When sat_clr and a counted transfer coincide, sat_clr wins and the count becomes 0.

Verification (WIDTH=24, FRAC=20)
REQ-028 Tanh: inputs 0x0C0000, 0xF40000, 0x180000 -> outputs 0x0A0000, 0xF60000, 0x0E0000, each 2 cycles after its input handshake, o_sat = 0.
REQ-029 Tanh saturation: inputs 0x300000, then 0x800000 -> 0x100000, then 0xF00000, o_sat = 1 for both; sat_cnt = 2 when the macro is defined.
REQ-030 Sigmoid: inputs 0x000000, 0x200000, 0xE00000 -> outputs 0x080000, 0x0E0000, 0x020000, o_sat = 0.
REQ-031 Backpressure: 4 back-to-back inputs with o_ready held 0 for cycles 3-6 -> i_ready falls while o_valid & ~o_ready; all 4 results arrive in order with o_data stable during the stall.
REQ-032 Reset mid-stream: rst_n pulsed low with 2 operands in flight -> o_valid = 0 immediately, no stale output afterwards, i_ready = 1 the cycle after release.
REQ-033 Counter: with sat_cnt at 0xFFFF, one further saturated transfer -> sat_cnt stays 0xFFFF; sat_clr coinciding with a saturated transfer -> sat_cnt = 0.

Source files
------------

// File: rtl/act_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : act_pwl
//  Description : Two-stage piecewise-linear tanh / sigmoid activation with a
//                global-stall valid/ready pipeline. The optional saturation
//                counter (sat_clr / sat_cnt) is built when ACT_PWL_SATCNT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module act_pwl #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sat
`ifdef ACT_PWL_SATCNT_EN
    ,
    input  logic             sat_clr,
    output logic [15:0]      sat_cnt
`endif
);

    localparam logic signed [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0] c_half    = c_one >>> 1;
    localparam logic signed [WIDTH-1:0] c_quarter = c_one >>> 2;

    // Region thresholds on |v|, one bit wider so the most negative v fits.
    localparam logic [WIDTH:0] c_half_a = {{WIDTH{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [WIDTH:0] c_one_a  = {{WIDTH{1'b0}}, 1'b1} << FRAC;
    localparam logic [WIDTH:0] c_two_a  = {{WIDTH{1'b0}}, 1'b1} << (FRAC + 1);

    localparam logic [1:0] c_reg_lin  = 2'd0;
    localparam logic [1:0] c_reg_half = 2'd1;
    localparam logic [1:0] c_reg_quar = 2'd2;
    localparam logic [1:0] c_reg_sat  = 2'd3;

    logic                    r_s1_valid_q, w_s1_valid_d;
    logic signed [WIDTH-1:0] r_s1_v_q,     w_s1_v_d;
    logic                    r_s1_mode_q,  w_s1_mode_d;
    logic                    r_s1_neg_q,   w_s1_neg_d;
    logic [1:0]              r_s1_reg_q,   w_s1_reg_d;
    logic                    r_o_valid_q,  w_o_valid_d;
    logic [WIDTH-1:0]        r_o_data_q,   w_o_data_d;
    logic                    r_o_sat_q,    w_o_sat_d;

    logic                    w_enable;
    logic signed [WIDTH-1:0] w_v;
    logic signed [WIDTH:0]   w_v_ext;
    logic [WIDTH:0]          w_abs;
    logic [1:0]              w_region;
    logic signed [WIDTH-1:0] w_t;
    logic signed [WIDTH-1:0] w_result;

    // Stage 1: sigmoid evaluates T on x/2, so the halving happens before classification.
    always_comb begin
        w_v      = i_mode ? ($signed(i_data) >>> 1) : $signed(i_data);
        w_v_ext  = {w_v[WIDTH-1], w_v};
        w_abs    = w_v[WIDTH-1] ? $unsigned(-w_v_ext) : $unsigned(w_v_ext);
        w_region = c_reg_sat;
        if (w_abs < c_half_a) begin
            w_region = c_reg_lin;
        end else if (w_abs < c_one_a) begin
            w_region = c_reg_half;
        end else if (w_abs < c_two_a) begin
            w_region = c_reg_quar;
        end
    end

    // Stage 2: segment evaluation and sigmoid remap.
    always_comb begin
        case (r_s1_reg_q)
            c_reg_lin:  w_t = r_s1_v_q;
            c_reg_half: w_t = (r_s1_v_q >>> 1) + (r_s1_neg_q ? -c_quarter : c_quarter);
            c_reg_quar: w_t = (r_s1_v_q >>> 2) + (r_s1_neg_q ? -c_half : c_half);
            default:    w_t = r_s1_neg_q ? -c_one : c_one;
        endcase
        w_result = r_s1_mode_q ? (c_half + (w_t >>> 1)) : w_t;
    end

    always_comb begin
        w_enable     = ~r_o_valid_q | o_ready;
        w_s1_valid_d = r_s1_valid_q;
        w_s1_v_d     = r_s1_v_q;
        w_s1_mode_d  = r_s1_mode_q;
        w_s1_neg_d   = r_s1_neg_q;
        w_s1_reg_d   = r_s1_reg_q;
        w_o_valid_d  = r_o_valid_q;
        w_o_data_d   = r_o_data_q;
        w_o_sat_d    = r_o_sat_q;
        if (w_enable) begin
            w_s1_valid_d = i_valid;
            if (i_valid) begin
                w_s1_v_d    = w_v;
                w_s1_mode_d = i_mode;
                w_s1_neg_d  = w_v[WIDTH-1];
                w_s1_reg_d  = w_region;
            end
            w_o_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_o_data_d = w_result;
                w_o_sat_d  = (r_s1_reg_q == c_reg_sat);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid_q <= 1'b0;
            r_s1_v_q     <= '0;
            r_s1_mode_q  <= 1'b0;
            r_s1_neg_q   <= 1'b0;
            r_s1_reg_q   <= c_reg_lin;
            r_o_valid_q  <= 1'b0;
            r_o_data_q   <= '0;
            r_o_sat_q    <= 1'b0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_v_q     <= w_s1_v_d;
            r_s1_mode_q  <= w_s1_mode_d;
            r_s1_neg_q   <= w_s1_neg_d;
            r_s1_reg_q   <= w_s1_reg_d;
            r_o_valid_q  <= w_o_valid_d;
            r_o_data_q   <= w_o_data_d;
            r_o_sat_q    <= w_o_sat_d;
        end
    end

    assign i_ready = w_enable;
    assign o_valid = r_o_valid_q;
    assign o_data  = r_o_data_q;
    assign o_sat   = r_o_sat_q;

`ifdef ACT_PWL_SATCNT_EN
    logic [15:0] r_sat_cnt_q, w_sat_cnt_d;

    // Clear takes priority over a coincident counted transfer.
    always_comb begin
        w_sat_cnt_d = r_sat_cnt_q;
        if (sat_clr) begin
            w_sat_cnt_d = '0;
        end else if (r_o_valid_q && o_ready && r_o_sat_q && (r_sat_cnt_q != 16'hFFFF)) begin
            w_sat_cnt_d = r_sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt_q <= '0;
        end else begin
            r_sat_cnt_q <= w_sat_cnt_d;
        end
    end

    assign sat_cnt = r_sat_cnt_q;
`endif

endmodule
`default_nettype wire
